// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - micro-coded instruction control sequencer
// Walks fetch, decode and per-opcode execute chains; tracks retires, illegal decodes and HALT.
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instr,
  output logic [7:0]  state,
  output logic        busy,
  output logic        retire,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] instr_count
);

  typedef enum logic [7:0] {
    S_IDLE   = 8'h00,
    S_DECODE = 8'h01,
    S_LOAD   = 8'h02,
    S_MOVE   = 8'h03,
    S_LDPC   = 8'h04,
    S_BRANCH = 8'h05,
    S_SUB0   = 8'h06, S_SUB1  = 8'h07, S_SUB2  = 8'h08,
    S_ADD0   = 8'h09, S_ADD1  = 8'h0A, S_ADD2  = 8'h0B,
    S_XOR0   = 8'h0C, S_XOR1  = 8'h0D, S_XOR2  = 8'h0E,
    S_FETCH  = 8'h0F,
    S_PUSH0  = 8'h13, S_PUSH1 = 8'h14, S_PUSH2 = 8'h15, S_PUSH3 = 8'h16,
    S_POP0   = 8'h17, S_POP1  = 8'h18, S_POP2  = 8'h19, S_POP3  = 8'h1A,
    S_CALL0  = 8'h1B, S_CALL1 = 8'h1C, S_CALL2 = 8'h1D,
    S_CALL3  = 8'h1E, S_CALL4 = 8'h1F, S_CALL5 = 8'h20,
    S_RET0   = 8'h21, S_RET1  = 8'h22, S_RET2  = 8'h23, S_RET3  = 8'h24,
    S_HALT   = 8'h3F
  } state_e;

  state_e      state_q, state_d;
  logic        retire_q, retire_d;
  logic        illegal_q, illegal_d;
  logic [15:0] count_q, count_d;
  logic        finish;
  logic        unused_operand_bits;

  // Only the opcode nibble steers sequencing; rx/ry feed the datapath elsewhere.
  assign unused_operand_bits = ^instr[11:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retire_d  = 1'b0;
    illegal_d = illegal_q;
    count_d   = count_q;
    finish    = 1'b0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (instr[15:12])
          4'h0:    state_d = S_LOAD;
          4'h1:    state_d = S_MOVE;
          4'h2:    state_d = S_LDPC;
          4'h3:    state_d = S_BRANCH;
          4'h4:    state_d = S_SUB0;
          4'h5:    state_d = S_ADD0;
          4'h6:    state_d = S_XOR0;
          4'h7:    state_d = S_PUSH0;
          4'h8:    state_d = S_POP0;
          4'h9:    state_d = S_CALL0;
          4'hA:    state_d = S_RET0;
          4'hF:    state_d = S_HALT;
          default: begin
            state_d   = S_IDLE;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_LOAD, S_MOVE, S_LDPC, S_BRANCH,
      S_SUB2, S_ADD2, S_XOR2, S_PUSH3, S_POP3, S_CALL5, S_RET3:
        finish = 1'b1;
      // Intermediate chain codes are contiguous, so each step is a plain increment.
      S_SUB0, S_SUB1, S_ADD0, S_ADD1, S_XOR0, S_XOR1,
      S_PUSH0, S_PUSH1, S_PUSH2, S_POP0, S_POP1, S_POP2,
      S_CALL0, S_CALL1, S_CALL2, S_CALL3, S_CALL4,
      S_RET0, S_RET1, S_RET2:
        state_d = state_e'(state_q + 8'd1);
      S_HALT:   state_d = S_HALT;
      default: begin
        state_d   = S_IDLE;
        illegal_d = 1'b1;
      end
    endcase
    if (finish) begin
      state_d  = S_IDLE;
      retire_d = 1'b1;
      count_d  = count_q + 16'd1;
    end
  end

  assign state       = state_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted      = (state_q == S_HALT);
  assign retire      = retire_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized bench for control_sequencer against a table-driven model
// Expected state walks come from per-opcode entry codes and instruction latencies.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instr;
  logic [7:0]  state;
  logic        busy, retire, halted, illegal;
  logic [15:0] instr_count;

  int          vectors = 0;
  int          errs = 0;
  logic [15:0] m_count;
  logic        m_illegal;

  logic [7:0]  first_tab [0:10] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h09,
                                    8'h0C, 8'h13, 8'h17, 8'h1B, 8'h21};
  int          lat_tab   [0:10] = '{4, 4, 4, 4, 6, 6, 6, 7, 7, 9, 7};

  control_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .instr       (instr),
    .state       (state),
    .busy        (busy),
    .retire      (retire),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] exp_state, input logic exp_retire);
    chk({tag, ".state"},   32'(state), 32'(exp_state));
    chk({tag, ".retire"},  32'(retire), 32'(exp_retire));
    chk({tag, ".count"},   32'(instr_count), 32'(m_count));
    chk({tag, ".illegal"}, 32'(illegal), 32'(m_illegal));
    chk({tag, ".busy"},    32'(busy), 32'(exp_state != 8'h00 && exp_state != 8'h3F));
    chk({tag, ".halted"},  32'(halted), 32'(exp_state == 8'h3F));
  endtask

  // Runs one instruction from state 0x00; stop_at >= 0 truncates after that many edges.
  task automatic do_instr(input string tag, input logic [15:0] iw, input int stop_at);
    logic [7:0] seq[$];
    logic [7:0] cur;
    int  op;
    bit  legal, bad, last;
    op    = int'(iw[15:12]);
    legal = (op <= 10);
    bad   = (op >= 11 && op <= 14);
    seq.push_back(8'h0F);
    seq.push_back(8'h01);
    if (legal) begin
      for (int i = 0; i < lat_tab[op] - 3; i++) seq.push_back(first_tab[op] + 8'(i));
      seq.push_back(8'h00);
    end else if (bad) begin
      seq.push_back(8'h00);
    end else begin
      seq.push_back(8'h3F);
    end
    for (int k = 0; k < seq.size(); k++) begin
      if (stop_at >= 0 && k >= stop_at) break;
      cur   = (k == 0) ? 8'h00 : seq[k-1];
      run   = (cur == 8'h00) ? 1'b1 : 1'($urandom_range(0, 1));
      instr = (cur == 8'h01) ? iw : 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      last = (k == seq.size() - 1);
      if (last && legal) m_count++;
      if (last && bad) m_illegal = 1'b1;
      chk_all(tag, seq[k], last && legal);
    end
  endtask

  initial begin
    reset     = 1'b1;
    run       = 1'b0;
    instr     = 16'h0000;
    m_count   = 16'h0000;
    m_illegal = 1'b0;
    #1;
    chk_all("reset_async", 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run   = 1'b0;
      instr = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk_all("run_hold", 8'h00, 1'b0);
    end

    do_instr("load", 16'h0123, -1);
    do_instr("add",  16'h5120, -1);
    do_instr("call", 16'h9000, -1);
    do_instr("ret",  16'hA000, -1);

    for (int i = 0; i < 40; i++)
      do_instr("rand", {4'($urandom_range(0, 10)), 12'($urandom)}, -1);

    do_instr("illegal_c", 16'hC000, -1);
    do_instr("after_ill", 16'h4321, -1);

    for (int i = 0; i < 40; i++)
      do_instr("rand_ill", {4'($urandom_range(0, 14)), 12'($urandom)}, -1);

    force dut.count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.count_q;
    m_count = 16'hFFFF;
    do_instr("wrap", 16'h1234, -1);
    chk("wrap.zero", 32'(instr_count), 32'h0);

    do_instr("pop_part", 16'h8000, 5);
    chk("pop_at_19", 32'(state), 32'h19);
    #2 reset = 1'b1;
    #1;
    m_count   = 16'h0000;
    m_illegal = 1'b0;
    chk_all("reset_mid", 8'h00, 1'b0);
    run = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    chk_all("post_reset_idle", 8'h00, 1'b0);
    do_instr("post_reset", 16'h7abc, -1);

    do_instr("halt", 16'hF000, -1);
    for (int i = 0; i < 20; i++) begin
      run   = ~run;
      instr = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk_all("halt_hold", 8'h3F, 1'b0);
    end
    reset = 1'b1;
    #1;
    m_count   = 16'h0000;
    m_illegal = 1'b0;
    chk_all("halt_reset", 8'h00, 1'b0);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_instr("final", 16'h2000, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
